// File: rtl/sos_pattern_module_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sos_pattern_module_pkg
// Brief    : Shared Morse timing constants, FSM states and element record for
//            the SOS pattern generator.
// Revision : 1.0 - initial release
// ============================================================================
package sos_pattern_module_pkg;

  localparam int DOT_UNITS    = 1;
  localparam int DASH_UNITS   = 3;
  localparam int SYM_GAP      = 1;
  localparam int LETTER_GAP   = 3;
  localparam int NUM_ELEMENTS = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] on_units;
    logic [1:0] off_units;
  } element_t;

  // Ceiling log2; returns 0 for values of 1 or less.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sos_unit_timer.sv
`default_nettype none
// ============================================================================
// Module   : sos_unit_timer
// Brief    : Free-running Morse unit divider; one-cycle Unit_Tick every
//            UNIT_CYCLES cycles after Clear is released.
// Revision : 1.0 - initial release
// ============================================================================
module sos_unit_timer
  import sos_pattern_module_pkg::*;
#(
  parameter int UNIT_CYCLES = 5_000_000
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic Clear,
  output logic Unit_Tick
);

  localparam int              CNT_W  = (clog2(UNIT_CYCLES) < 1) ? 1 : clog2(UNIT_CYCLES);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(UNIT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_terminal;

  assign w_terminal = (r_cnt == c_last);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_cnt <= '0;
    end else if (Clear || w_terminal) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Left ungated by Clear: the parent derives Clear from this tick.
  assign Unit_Tick = w_terminal;

endmodule
`default_nettype wire

// File: rtl/sos_pattern_module.sv
`default_nettype none
// ============================================================================
// Module   : sos_pattern_module
// Brief    : Plays one Morse "SOS" burst on Pin_Out per accepted start pulse.
// Revision : 1.0 - initial release
// ============================================================================
module sos_pattern_module
  import sos_pattern_module_pkg::*;
#(
  parameter int UNIT_CYCLES = 5_000_000
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic Start_Sig,
  output logic Pin_Out,
  output logic Busy,
  output logic Done_Sig
);

  localparam logic [3:0] c_last_idx = 4'(NUM_ELEMENTS - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_idx;
  logic [3:0] w_idx_nxt;
  logic [1:0] r_units;
  logic [1:0] w_units_nxt;
  logic       r_start_prev;
  logic       r_pin;
  logic       r_busy;
  logic       r_done;
  logic       w_done_nxt;
  logic       w_clear;
  logic       w_unit_tick;
  element_t   w_elem;

  sos_unit_timer #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_unit_timer (
    .CLK      (CLK),
    .RST_n    (RST_n),
    .Clear    (w_clear),
    .Unit_Tick(w_unit_tick)
  );

  always_comb begin
    w_elem = '{on_units: 2'd0, off_units: 2'd0};
    case (r_idx)
      4'd0, 4'd1: w_elem = '{on_units: 2'(DOT_UNITS),  off_units: 2'(SYM_GAP)};
      4'd2:       w_elem = '{on_units: 2'(DOT_UNITS),  off_units: 2'(LETTER_GAP)};
      4'd3, 4'd4: w_elem = '{on_units: 2'(DASH_UNITS), off_units: 2'(SYM_GAP)};
      4'd5:       w_elem = '{on_units: 2'(DASH_UNITS), off_units: 2'(LETTER_GAP)};
      4'd6, 4'd7: w_elem = '{on_units: 2'(DOT_UNITS),  off_units: 2'(SYM_GAP)};
      4'd8:       w_elem = '{on_units: 2'(DOT_UNITS),  off_units: 2'd0};
      default:    w_elem = '{on_units: 2'd0, off_units: 2'd0};
    endcase
  end

  // Start is edge-qualified so a held trigger cannot re-launch a burst.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_units_nxt = r_units;
    w_clear     = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_clear     = 1'b1;
        w_idx_nxt   = 4'd0;
        w_units_nxt = 2'd0;
        if (Start_Sig && !r_start_prev) begin
          w_state_nxt = ST_ON;
        end
      end
      ST_ON: begin
        if (w_unit_tick) begin
          if (r_units == w_elem.on_units - 2'd1) begin
            w_clear     = 1'b1;
            w_units_nxt = 2'd0;
            if (w_elem.off_units == 2'd0 || r_idx == c_last_idx) begin
              w_state_nxt = ST_IDLE;
              w_idx_nxt   = 4'd0;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_OFF;
            end
          end else begin
            w_units_nxt = r_units + 2'd1;
          end
        end
      end
      ST_OFF: begin
        if (w_unit_tick) begin
          if (r_units == w_elem.off_units - 2'd1) begin
            w_clear     = 1'b1;
            w_units_nxt = 2'd0;
            w_state_nxt = ST_ON;
            w_idx_nxt   = r_idx + 4'd1;
          end else begin
            w_units_nxt = r_units + 2'd1;
          end
        end
      end
      default: begin
        w_clear     = 1'b1;
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = 4'd0;
        w_units_nxt = 2'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state      <= ST_IDLE;
      r_idx        <= 4'd0;
      r_units      <= 2'd0;
      r_start_prev <= 1'b0;
      r_pin        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_units      <= w_units_nxt;
      r_start_prev <= Start_Sig;
      r_pin        <= (w_state_nxt == ST_ON);
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_done       <= w_done_nxt;
    end
  end

  assign Pin_Out  = r_pin;
  assign Busy     = r_busy;
  assign Done_Sig = r_done;

endmodule
`default_nettype wire
